// File: rtl/kernel_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : kernel_window_ctrl
//  Description : Raster timing controller for a 5x5 line-buffer window.
//                Tracks row/column position from dv/hs/vs, drives the shared
//                line-buffer write address, flags when the window is full,
//                and measures frame width/height with error reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module kernel_window_ctrl #(
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_dv,
    input  logic              rx_hs,
    input  logic              rx_vs,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic              kernel_valid,
    output logic [ADDR_W-1:0] center_x,
    output logic [CNT_W-1:0]  center_y,
    output logic [ADDR_W:0]   width,
    output logic [CNT_W-1:0]  height,
    output logic              frame_done,
    output logic              line_err,
    output logic              ovf_err
);

    // Column counter is one bit wider than the address so it can reach the
    // full line length, which is the overflow marker.
    localparam logic [ADDR_W:0]   COL_MAX = (ADDR_W+1)'(1) << ADDR_W;
    localparam logic [ADDR_W:0]   COL_K   = (ADDR_W+1)'(4);
    localparam logic [CNT_W-1:0]  ROW_K   = CNT_W'(4);
    localparam logic [CNT_W-1:0]  ROW_MAX = '1;

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        LINE    = 2'd1,
        HBLANK  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                vs_q, hs_q;
    logic [CNT_W-1:0]    row_q, row_d;
    logic [ADDR_W:0]     col_q, col_d;
    logic [ADDR_W:0]     col_eff;
    logic [ADDR_W:0]     width_q, width_d;
    logic                wvalid_q, wvalid_d;
    logic [CNT_W-1:0]    height_q, height_d;
    logic                ovf_q, ovf_d;
    logic                kv_q, kv_d;
    logic [ADDR_W-1:0]   cx_q, cx_d;
    logic [CNT_W-1:0]    cy_q, cy_d;
    logic                fd_q, fd_d;
    logic                le_q, le_d;
    logic                accept;
    logic                vs_rise, hs_rise;

    assign vs_rise = rx_vs & ~vs_q;
    assign hs_rise = rx_hs & ~hs_q;

    // Next-state: sync edges, pixel acceptance, end-of-row and end-of-frame.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        col_eff  = col_q;
        width_d  = width_q;
        wvalid_d = wvalid_q;
        height_d = height_q;
        ovf_d    = ovf_q;
        kv_d     = 1'b0;
        cx_d     = cx_q;
        cy_d     = cy_q;
        fd_d     = 1'b0;
        le_d     = 1'b0;
        accept   = 1'b0;

        case (state_q)
            WAIT_VS: begin
                if (vs_rise) begin
                    state_d  = HBLANK;
                    row_d    = '0;
                    col_d    = '0;
                    wvalid_d = 1'b0;
                end
            end
            default: begin
                if (vs_rise) begin
                    // Frame end wins over any pixel or hs in the same cycle.
                    state_d  = HBLANK;
                    row_d    = '0;
                    col_d    = '0;
                    wvalid_d = 1'b0;
                    if (row_q != '0 || col_q != '0) begin
                        fd_d     = 1'b1;
                        height_d = (col_q != '0 && row_q != ROW_MAX) ?
                                   row_q + CNT_W'(1) : row_q;
                    end
                end else begin
                    if (rx_dv) begin
                        if (col_q == COL_MAX) begin
                            ovf_d = 1'b1;
                        end else begin
                            accept  = 1'b1;
                            col_eff = col_q + (ADDR_W+1)'(1);
                            if (row_q >= ROW_K && col_q >= COL_K) begin
                                kv_d = 1'b1;
                                cx_d = col_q[ADDR_W-1:0] - ADDR_W'(2);
                                cy_d = row_q - CNT_W'(2);
                            end
                            if (state_q == HBLANK) begin
                                state_d = LINE;
                            end
                        end
                    end
                    col_d = col_eff;
                    // A pixel arriving with hs is counted before the row closes.
                    if (state_q == LINE && hs_rise) begin
                        state_d = HBLANK;
                        if (row_q == '0) begin
                            width_d  = col_eff;
                            wvalid_d = 1'b1;
                        end else if (wvalid_q && col_eff != width_q) begin
                            le_d = 1'b1;
                        end
                        if (row_q != ROW_MAX) begin
                            row_d = row_q + CNT_W'(1);
                        end
                        col_d = '0;
                    end
                end
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= WAIT_VS;
            vs_q     <= 1'b0;
            hs_q     <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            width_q  <= '0;
            wvalid_q <= 1'b0;
            height_q <= '0;
            ovf_q    <= 1'b0;
            kv_q     <= 1'b0;
            cx_q     <= '0;
            cy_q     <= '0;
            fd_q     <= 1'b0;
            le_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            vs_q     <= rx_vs;
            hs_q     <= rx_hs;
            row_q    <= row_d;
            col_q    <= col_d;
            width_q  <= width_d;
            wvalid_q <= wvalid_d;
            height_q <= height_d;
            ovf_q    <= ovf_d;
            kv_q     <= kv_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            fd_q     <= fd_d;
            le_q     <= le_d;
        end
    end

    // Write strobe is masked during reset so nothing lands in the buffers.
    assign buf_we       = accept & ~rst;
    assign buf_addr     = col_q[ADDR_W-1:0];
    assign kernel_valid = kv_q;
    assign center_x     = cx_q;
    assign center_y     = cy_q;
    assign width        = width_q;
    assign height       = height_q;
    assign frame_done   = fd_q;
    assign line_err     = le_q;
    assign ovf_err      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_kernel_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kernel_window_ctrl
//  Description : Self-checking bench for kernel_window_ctrl with a
//                frame/row-level reference model and randomized raster input.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_kernel_window_ctrl;

    localparam int AW   = 3;
    localparam int CW   = 5;
    localparam int LMAX = 1 << AW;
    localparam int RMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_dv = 1'b0;
    logic          rx_hs = 1'b0;
    logic          rx_vs = 1'b0;
    logic          buf_we;
    logic [AW-1:0] buf_addr;
    logic          kernel_valid;
    logic [AW-1:0] center_x;
    logic [CW-1:0] center_y;
    logic [AW:0]   width;
    logic [CW-1:0] height;
    logic          frame_done;
    logic          line_err;
    logic          ovf_err;

    kernel_window_ctrl #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_hs(rx_hs), .rx_vs(rx_vs),
        .buf_we(buf_we), .buf_addr(buf_addr), .kernel_valid(kernel_valid),
        .center_x(center_x), .center_y(center_y), .width(width),
        .height(height), .frame_done(frame_done), .line_err(line_err),
        .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: position within the raster and measured frame data.
    int m_row, m_col, m_width, m_height, m_kvcnt;
    bit m_sync, m_inrow, m_ovf, m_pvs, m_phs;
    bit e_we, e_kv, e_fd, e_le;
    int e_addr, e_cx, e_cy;

    // Observed event counters for step-level checks.
    int obs_kv, obs_we, obs_le, obs_fd;
    int first_cx, first_cy;
    bit got_first;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_row = 0; m_col = 0; m_width = 0; m_height = 0; m_kvcnt = 0;
        m_sync = 0; m_inrow = 0; m_ovf = 0; m_pvs = 0; m_phs = 0;
        e_we = 0; e_kv = 0; e_fd = 0; e_le = 0;
        e_addr = 0; e_cx = 0; e_cy = 0;
    endtask

    task automatic model_step(input bit dv, input bit hs, input bit vs);
        bit vr, hr, was_in;
        int h;
        vr = vs && !m_pvs;
        hr = hs && !m_phs;
        m_pvs = vs;
        m_phs = hs;
        was_in = m_inrow;
        e_we = 0; e_kv = 0; e_fd = 0; e_le = 0;
        e_addr = m_col % LMAX;
        if (vr) begin
            if (m_sync && (m_row > 0 || m_col > 0)) begin
                e_fd = 1;
                h = m_row + ((m_col > 0) ? 1 : 0);
                m_height = (h > RMAX) ? RMAX : h;
            end
            m_sync = 1; m_row = 0; m_col = 0; m_inrow = 0;
        end else if (m_sync) begin
            if (dv) begin
                if (m_col < LMAX) begin
                    e_we = 1;
                    if (m_row >= 4 && m_col >= 4) begin
                        e_kv = 1; e_cx = m_col - 2; e_cy = m_row - 2; m_kvcnt++;
                    end
                    m_col++;
                    m_inrow = 1;
                end else begin
                    m_ovf = 1;
                end
            end
            if (hr && was_in) begin
                if (m_row == 0) m_width = m_col;
                else if (m_col != m_width) e_le = 1;
                m_row = (m_row + 1 > RMAX) ? RMAX : m_row + 1;
                m_col = 0;
                m_inrow = 0;
            end
        end
    endtask

    task automatic chk_regs();
        chk("kernel_valid", kernel_valid, e_kv);
        chk("center_x", center_x, e_cx);
        chk("center_y", center_y, e_cy);
        chk("width", width, m_width);
        chk("height", height, m_height);
        chk("frame_done", frame_done, e_fd);
        chk("line_err", line_err, e_le);
        chk("ovf_err", ovf_err, m_ovf);
    endtask

    // One clock cycle: drive inputs, check write port, clock, check registers.
    task automatic cyc(input bit dv, input bit hs, input bit vs);
        rx_dv = dv; rx_hs = hs; rx_vs = vs;
        #1;
        model_step(dv, hs, vs);
        chk("buf_we", buf_we, e_we);
        chk("buf_addr", buf_addr, e_addr);
        if (buf_we) obs_we++;
        @(posedge clk); #1;
        chk_regs();
        if (kernel_valid) begin
            obs_kv++;
            if (!got_first) begin
                got_first = 1; first_cx = center_x; first_cy = center_y;
            end
        end
        if (frame_done) obs_fd++;
        if (line_err) obs_le++;
    endtask

    task automatic do_reset(input bit dv);
        rst = 1; rx_dv = dv; rx_hs = 0; rx_vs = 0;
        #1;
        chk("we_during_rst", buf_we, 1'b0);
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        chk("rst_buf_addr", buf_addr, 0);
        chk("rst_kv", kernel_valid, 0);
        chk("rst_width", width, 0);
        chk("rst_height", height, 0);
        chk("rst_ovf", ovf_err, 0);
        chk_regs();
    endtask

    task automatic clr_obs();
        obs_kv = 0; obs_we = 0; obs_le = 0; obs_fd = 0; got_first = 0;
        m_kvcnt = 0;
    endtask

    task automatic pix(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) cyc(0, 0, 0);
            cyc(1, 0, 0);
        end
    endtask

    task automatic hs_pulse();
        cyc(0, 1, 0);
        cyc(0, 0, 0);
    endtask

    task automatic vs_pulse();
        cyc(0, 0, 1);
        cyc(0, 0, 0);
    endtask

    task automatic row(input int n, input bit gaps);
        pix(n, gaps);
        hs_pulse();
    endtask

    initial begin
        model_reset();
        @(posedge clk); #1;

        // Reset, then pixels before any vs are ignored.
        do_reset(0);
        do_reset(1);
        clr_obs();
        pix(4, 0);
        chk("dv_ignored_wait_vs", obs_we, 0);

        // 6 rows of 8 pixels: width, window count and first centre.
        vs_pulse();
        clr_obs();
        for (int r = 0; r < 6; r++) row(8, 1);
        chk("width_6x8", width, 8);
        chk("kv_count", obs_kv, m_kvcnt);
        chk("first_center_x", first_cx, 2);
        chk("first_center_y", first_cy, 2);

        // Frame end: single frame_done and height 6.
        clr_obs();
        vs_pulse();
        chk("frame_done_count", obs_fd, 1);
        chk("height_6", height, 6);

        // Short second row gives exactly one line_err; width unchanged.
        clr_obs();
        row(8, 1);
        row(7, 1);
        chk("line_err_count", obs_le, 1);
        chk("width_hold", width, 8);

        // Overflow: 10 pixels into an 8-entry line.
        vs_pulse();
        clr_obs();
        pix(10, 0);
        chk("ovf_we_count", obs_we, 8);
        chk("ovf_set", ovf_err, 1);
        hs_pulse();
        vs_pulse();
        chk("ovf_sticky", ovf_err, 1);

        // Pixel and hs together at col 7 of row 0.
        vs_pulse();
        row(5, 0);
        chk("width_5", width, 5);
        vs_pulse();
        pix(7, 0);
        rx_dv = 1; rx_hs = 1; rx_vs = 0;
        #1;
        chk("sim_hs_addr7", buf_addr, 7);
        chk("sim_hs_we", buf_we, 1);
        cyc(1, 1, 0);
        cyc(0, 0, 0);
        chk("width_sim_hs", width, 8);

        // Randomized frames with ragged rows and coincident sync events.
        for (int f = 0; f < 8; f++) begin
            int nrows, w0;
            nrows = $urandom_range(1, 7);
            w0 = $urandom_range(1, LMAX);
            vs_pulse();
            for (int r = 0; r < nrows; r++) begin
                int len;
                len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, LMAX) : w0;
                if ($urandom_range(0, 2) == 0) begin
                    pix(len - 1, 1);
                    cyc(1, 1, 0);
                    cyc(0, 0, 0);
                end else begin
                    row(len, 1);
                end
            end
            if ($urandom_range(0, 1) == 1) pix($urandom_range(1, 4), 1);
            if ($urandom_range(0, 1) == 1) cyc(1, 1, 1);
            else cyc(0, 0, 1);
            cyc(0, 0, 0);
        end

        // Row counter saturation.
        vs_pulse();
        for (int r = 0; r < 34; r++) row(1, 0);
        vs_pulse();
        chk("height_saturated", height, RMAX);

        // Reset mid-row 3, then dv is ignored until vs.
        vs_pulse();
        for (int r = 0; r < 3; r++) row(8, 0);
        pix(3, 0);
        do_reset(1);
        clr_obs();
        pix(5, 1);
        chk("dv_ignored_after_rst", obs_we, 0);
        vs_pulse();
        row(8, 1);
        chk("width_after_rst", width, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
